// File: rtl/memory_access_unit_pkg.sv
// rtl/memory_access_unit_pkg.sv - shared load/store opcodes, FSM states and access helpers
package memory_access_unit_pkg;

    localparam logic [5:0] ALU_LB  = 6'd18;
    localparam logic [5:0] ALU_LH  = 6'd19;
    localparam logic [5:0] ALU_LW  = 6'd20;
    localparam logic [5:0] ALU_LBU = 6'd21;
    localparam logic [5:0] ALU_LHU = 6'd22;
    localparam logic [5:0] ALU_SB  = 6'd23;
    localparam logic [5:0] ALU_SH  = 6'd24;
    localparam logic [5:0] ALU_SW  = 6'd25;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_LO = 3'd1,
        RD_HI = 3'd2,
        WR    = 3'd3,
        RESP  = 3'd4
    } mau_state_e;

    function automatic logic op_is_load(input logic [5:0] op);
        return (op == ALU_LB) || (op == ALU_LH) || (op == ALU_LW) ||
               (op == ALU_LBU) || (op == ALU_LHU);
    endfunction

    function automatic logic op_is_store(input logic [5:0] op);
        return (op == ALU_SB) || (op == ALU_SH) || (op == ALU_SW);
    endfunction

    // Access width in bytes; 0 for anything that is not a load/store.
    function automatic logic [2:0] op_bytes(input logic [5:0] op);
        logic [2:0] n;
        n = 3'd0;
        if ((op == ALU_LB) || (op == ALU_LBU) || (op == ALU_SB)) n = 3'd1;
        if ((op == ALU_LH) || (op == ALU_LHU) || (op == ALU_SH)) n = 3'd2;
        if ((op == ALU_LW) || (op == ALU_SW))                    n = 3'd4;
        return n;
    endfunction

    function automatic logic op_misaligned(input logic [5:0] op, input logic [1:0] offset);
        logic [2:0] n;
        n = op_bytes(op);
        return ((n == 3'd2) && offset[0]) || ((n == 3'd4) && (offset != 2'b00));
    endfunction

endpackage

// File: rtl/memory_access_unit_load_aligner.sv
// rtl/memory_access_unit_load_aligner.sv - combinational load byte alignment and sign/zero extension
module load_aligner
    import memory_access_unit_pkg::*;
(
    input  logic [31:0] lo,
    input  logic [31:0] hi,
    input  logic [1:0]  offset,
    input  logic [5:0]  alucode,
    output logic [31:0] result
);

    logic [63:0] pair_shifted;
    logic [31:0] window;

    always_comb begin
        pair_shifted = {hi, lo} >> {offset, 3'b000};
        window       = pair_shifted[31:0];
        result       = 32'd0;
        case (alucode)
            ALU_LB:  result = {{24{window[7]}}, window[7:0]};
            ALU_LBU: result = {24'd0, window[7:0]};
            ALU_LH:  result = {{16{window[15]}}, window[15:0]};
            ALU_LHU: result = {16'd0, window[15:0]};
            ALU_LW:  result = window;
            default: result = 32'd0;
        endcase
    end

    logic unused_hi;
    assign unused_hi = ^pair_shifted[63:32];

endmodule

// File: rtl/memory_access_unit.sv
// rtl/memory_access_unit.sv - load/store unit: split misaligned accesses into word reads or byte writes
module memory_access_unit
    import memory_access_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_alucode,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        mem_is_store,
    output logic [5:0]  mem_alucode,
    output logic [31:0] mem_w_addr,
    output logic [7:0]  mem_w_data_byte,
    output logic [15:0] mem_w_data_half,
    output logic [31:0] mem_w_data_word,
    output logic [31:0] mem_r_addr,
    input  logic [31:0] mem_r_data_word,
    output logic        resp_valid,
    output logic [4:0]  resp_rd,
    output logic [31:0] resp_data
);

    mau_state_e  state_q, state_d;
    logic [5:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] hi_q, hi_d;
    logic [1:0]  cnt_q, cnt_d;

    logic        misaligned;
    logic [2:0]  nbytes;
    logic [1:0]  last_idx;
    logic [31:0] load_result;

    assign misaligned = op_misaligned(op_q, addr_q[1:0]);
    assign nbytes     = op_bytes(op_q);
    assign last_idx   = nbytes[1:0] - 2'd1;

    load_aligner u_load_aligner (
        .lo      (lo_q),
        .hi      (hi_q),
        .offset  (addr_q[1:0]),
        .alucode (op_q),
        .result  (load_result)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d    = req_alucode;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rd_d    = req_rd;
                    cnt_d   = 2'd0;
                    if (op_is_load(req_alucode))       state_d = RD_LO;
                    else if (op_is_store(req_alucode)) state_d = WR;
                    else                               state_d = RESP;
                end
            end
            RD_LO: begin
                lo_d    = mem_r_data_word;
                state_d = misaligned ? RD_HI : RESP;
            end
            RD_HI: begin
                hi_d    = mem_r_data_word;
                state_d = RESP;
            end
            WR: begin
                // Misaligned stores walk one byte per cycle until the last lane of the access.
                if (!misaligned || (cnt_q == last_idx)) begin
                    cnt_d   = 2'd0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready       = (state_q == IDLE);
        mem_is_store    = 1'b0;
        mem_alucode     = 6'd0;
        mem_w_addr      = 32'd0;
        mem_w_data_byte = 8'd0;
        mem_w_data_half = 16'd0;
        mem_w_data_word = 32'd0;
        mem_r_addr      = 32'd0;
        resp_valid      = 1'b0;
        resp_rd         = 5'd0;
        resp_data       = 32'd0;
        case (state_q)
            RD_LO: mem_r_addr = {addr_q[31:2], 2'b00};
            RD_HI: mem_r_addr = {addr_q[31:2], 2'b00} + 32'd4;
            WR: begin
                // Writes commit on the same edge as reset, so they are suppressed while rst is high.
                if (!rst) begin
                    mem_is_store = 1'b1;
                    if (misaligned) begin
                        mem_alucode     = ALU_SB;
                        mem_w_addr      = addr_q + {30'd0, cnt_q};
                        mem_w_data_byte = wdata_q[{cnt_q, 3'b000} +: 8];
                        mem_w_data_half = {8'd0, wdata_q[{cnt_q, 3'b000} +: 8]};
                        mem_w_data_word = {24'd0, wdata_q[{cnt_q, 3'b000} +: 8]};
                    end else begin
                        mem_alucode     = op_q;
                        mem_w_addr      = addr_q;
                        mem_w_data_byte = wdata_q[7:0];
                        mem_w_data_half = wdata_q[15:0];
                        mem_w_data_word = wdata_q;
                    end
                end
            end
            RESP: begin
                if (!rst) begin
                    resp_valid = 1'b1;
                    if (op_is_load(op_q)) begin
                        resp_rd   = rd_q;
                        resp_data = load_result;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= 6'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rd_q    <= 5'd0;
            lo_q    <= 32'd0;
            hi_q    <= 32'd0;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_memory_access_unit.sv
// tb/tb_memory_access_unit.sv - directed bench with byte-level memory model and per-cycle output compare
module tb_memory_access_unit;
    import memory_access_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_alucode;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        mem_is_store;
    logic [5:0]  mem_alucode;
    logic [31:0] mem_w_addr;
    logic [7:0]  mem_w_data_byte;
    logic [15:0] mem_w_data_half;
    logic [31:0] mem_w_data_word;
    logic [31:0] mem_r_addr;
    logic [31:0] mem_r_data_word;
    logic        resp_valid;
    logic [4:0]  resp_rd;
    logic [31:0] resp_data;

    always #5 clk = ~clk;

    memory_access_unit dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_alucode     (req_alucode),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .req_rd          (req_rd),
        .mem_is_store    (mem_is_store),
        .mem_alucode     (mem_alucode),
        .mem_w_addr      (mem_w_addr),
        .mem_w_data_byte (mem_w_data_byte),
        .mem_w_data_half (mem_w_data_half),
        .mem_w_data_word (mem_w_data_word),
        .mem_r_addr      (mem_r_addr),
        .mem_r_data_word (mem_r_data_word),
        .resp_valid      (resp_valid),
        .resp_rd         (resp_rd),
        .resp_data       (resp_data)
    );

    // Data memory seen by the DUT (1 KB, aliased) and the bench's own expected copy.
    logic [31:0] mem     [0:255];
    logic [31:0] exp_mem [0:255];
    logic        pre_we;
    logic [7:0]  pre_idx;
    logic [31:0] pre_data;
    logic [31:0] wmerge;

    assign mem_r_data_word = mem[mem_r_addr[9:2]];

    always_comb begin
        wmerge = mem[mem_w_addr[9:2]];
        if (mem_alucode == ALU_SB)      wmerge[8*mem_w_addr[1:0] +: 8] = mem_w_data_byte;
        else if (mem_alucode == ALU_SH) wmerge[16*mem_w_addr[1] +: 16] = mem_w_data_half;
        else if (mem_alucode == ALU_SW) wmerge = mem_w_data_word;
    end

    always @(posedge clk) begin
        if (pre_we)            mem[pre_idx] <= pre_data;
        else if (mem_is_store) mem[mem_w_addr[9:2]] <= wmerge;
    end

    typedef struct {
        logic        ready;
        logic        rvalid;
        logic [4:0]  rd;
        logic [31:0] rdata;
        logic        st;
        logic [5:0]  op;
        logic [31:0] waddr;
        logic [7:0]  wb;
        logic [15:0] wh;
        logic [31:0] ww;
        logic        chk_hw;
        logic [31:0] raddr;
    } exp_t;

    exp_t        expq[$];
    exp_t        ce;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] last_resp = 32'h0;
    logic [4:0]  last_rd = 5'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    function automatic exp_t quiet(input logic ready);
        exp_t e;
        e.ready = ready; e.rvalid = 1'b0; e.rd = 5'd0; e.rdata = 32'd0;
        e.st = 1'b0; e.op = 6'd0; e.waddr = 32'd0; e.wb = 8'd0; e.wh = 16'd0;
        e.ww = 32'd0; e.chk_hw = 1'b1; e.raddr = 32'd0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_no_store", {31'd0, mem_is_store}, 32'd0);
            chk("rst_no_resp", {31'd0, resp_valid}, 32'd0);
        end else begin
            if (expq.size() > 0) ce = expq.pop_front();
            else                 ce = quiet(1'b1);
            chk("req_ready", {31'd0, req_ready}, {31'd0, ce.ready});
            chk("resp_valid", {31'd0, resp_valid}, {31'd0, ce.rvalid});
            chk("resp_rd", {27'd0, resp_rd}, {27'd0, ce.rd});
            chk("resp_data", resp_data, ce.rdata);
            chk("mem_is_store", {31'd0, mem_is_store}, {31'd0, ce.st});
            chk("mem_alucode", {26'd0, mem_alucode}, {26'd0, ce.op});
            chk("mem_w_addr", mem_w_addr, ce.waddr);
            chk("mem_w_data_byte", {24'd0, mem_w_data_byte}, {24'd0, ce.wb});
            if (ce.chk_hw) begin
                chk("mem_w_data_half", {16'd0, mem_w_data_half}, {16'd0, ce.wh});
                chk("mem_w_data_word", mem_w_data_word, ce.ww);
            end
            chk("mem_r_addr", mem_r_addr, ce.raddr);
            if (resp_valid) begin
                last_resp = resp_data;
                last_rd   = resp_rd;
            end
        end
    end

    function automatic logic [7:0] get_byte(input logic [31:0] a);
        logic [31:0] w;
        w = exp_mem[a[9:2]];
        return w[8*a[1:0] +: 8];
    endfunction

    task automatic set_byte(input logic [31:0] a, input logic [7:0] b);
        logic [31:0] w;
        w = exp_mem[a[9:2]];
        w[8*a[1:0] +: 8] = b;
        exp_mem[a[9:2]] = w;
    endtask

    // Model: an access touches bytes addr..addr+n-1; a load needs one word read per distinct word,
    // a misaligned store is issued as n single-byte writes, then one response cycle.
    task automatic run_op(input logic [5:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [4:0] rd);
        int          n;
        bit          ld, st, mis;
        logic [31:0] v;
        logic [31:0] base;
        exp_t        e;
        ld = (op == ALU_LB) || (op == ALU_LBU) || (op == ALU_LH) || (op == ALU_LHU) || (op == ALU_LW);
        st = (op == ALU_SB) || (op == ALU_SH) || (op == ALU_SW);
        n  = 0;
        if ((op == ALU_LB) || (op == ALU_LBU) || (op == ALU_SB)) n = 1;
        if ((op == ALU_LH) || (op == ALU_LHU) || (op == ALU_SH)) n = 2;
        if ((op == ALU_LW) || (op == ALU_SW))                    n = 4;
        mis  = (n > 1) && ((addr % n) != 0);
        base = addr & 32'hFFFF_FFFC;

        @(posedge clk); #1;
        req_valid = 1'b1; req_alucode = op; req_addr = addr; req_wdata = wdata; req_rd = rd;
        @(posedge clk); #1;
        req_valid = 1'b0; req_alucode = 6'd0; req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0;

        if (ld) begin
            e = quiet(1'b0); e.raddr = base; expq.push_back(e);
            if (mis) begin
                e = quiet(1'b0); e.raddr = base + 32'd4; expq.push_back(e);
            end
            v = 32'd0;
            for (int i = 0; i < n; i++) v = v | ({24'd0, get_byte(addr + i)} << (8 * i));
            if (op == ALU_LB && v[7])  v = v | 32'hFFFF_FF00;
            if (op == ALU_LH && v[15]) v = v | 32'hFFFF_0000;
            e = quiet(1'b0); e.rvalid = 1'b1; e.rd = rd; e.rdata = v; expq.push_back(e);
        end else if (st) begin
            if (!mis) begin
                e = quiet(1'b0); e.st = 1'b1; e.op = op; e.waddr = addr;
                e.wb = wdata[7:0]; e.wh = wdata[15:0]; e.ww = wdata;
                expq.push_back(e);
            end else begin
                for (int i = 0; i < n; i++) begin
                    e = quiet(1'b0); e.st = 1'b1; e.op = ALU_SB; e.waddr = addr + i;
                    e.wb = 8'(wdata >> (8 * i)); e.chk_hw = 1'b0;
                    expq.push_back(e);
                end
            end
            for (int i = 0; i < n; i++) set_byte(addr + i, 8'(wdata >> (8 * i)));
            e = quiet(1'b0); e.rvalid = 1'b1; expq.push_back(e);
        end else begin
            e = quiet(1'b0); e.rvalid = 1'b1; expq.push_back(e);
        end
        repeat (expq.size()) @(posedge clk);
    endtask

    task automatic run_reset_mid_store(input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        @(posedge clk); #1;
        req_valid = 1'b1; req_alucode = ALU_SW; req_addr = addr; req_wdata = wdata; req_rd = 5'd3;
        @(posedge clk); #1;
        req_valid = 1'b0; req_alucode = 6'd0; req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0;
        e = quiet(1'b0); e.st = 1'b1; e.op = ALU_SB; e.waddr = addr; e.wb = wdata[7:0]; e.chk_hw = 1'b0;
        expq.push_back(e);
        set_byte(addr, wdata[7:0]);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_alucode = 6'd0; req_addr = 32'd0;
        req_wdata = 32'd0; req_rd = 5'd0; pre_we = 1'b1; pre_idx = 8'd0; pre_data = 32'd0;
        for (int i = 0; i < 256; i++) begin
            pre_idx  = 8'(i);
            pre_data = (i == 8'h40) ? 32'hDEAD_BEEF :
                       (i == 255)   ? 32'hAB00_0000 :
                       (i == 0)     ? 32'h0000_0081 : 32'h0;
            exp_mem[i] = pre_data;
            @(posedge clk); #1;
        end
        pre_we = 1'b0;
        rst    = 1'b0;
        repeat (2) @(posedge clk);

        run_op(ALU_LW, 32'h100, 32'h0, 5'd5);
        chk("lit_lw_aligned", last_resp, 32'hDEAD_BEEF);
        chk("lit_lw_rd", {27'd0, last_rd}, 32'd5);
        run_op(ALU_SW, 32'h100, 32'h80FF_0000, 5'd9);
        run_op(ALU_LB, 32'h103, 32'h0, 5'd6);
        chk("lit_lb_sext", last_resp, 32'hFFFF_FF80);
        run_op(ALU_LBU, 32'h103, 32'h0, 5'd7);
        chk("lit_lbu_zext", last_resp, 32'h0000_0080);
        run_op(ALU_SW, 32'h100, 32'h4433_2211, 5'd0);
        run_op(ALU_SW, 32'h104, 32'h8877_6655, 5'd0);
        run_op(ALU_LW, 32'h102, 32'h0, 5'd8);
        chk("lit_lw_misaligned", last_resp, 32'h6655_4433);
        run_op(ALU_SW, 32'h1FF, 32'hAABB_CCDD, 5'd12);
        chk("lit_store_rd_zero", {27'd0, last_rd}, 32'd0);
        run_op(ALU_LW, 32'h1FF, 32'h0, 5'd10);
        chk("lit_lw_readback", last_resp, 32'hAABB_CCDD);
        run_op(ALU_LB, 32'h200, 32'h0, 5'd11);
        chk("lit_lb_200", last_resp, 32'hFFFF_FFCC);
        run_op(ALU_LH, 32'hFFFF_FFFF, 32'h0, 5'd13);
        chk("lit_lh_wrap", last_resp, 32'hFFFF_81AB);
        run_op(ALU_SH, 32'h301, 32'hFFFF_1234, 5'd0);
        run_op(ALU_LHU, 32'h301, 32'h0, 5'd14);
        chk("lit_lhu_misaligned", last_resp, 32'h0000_1234);
        run_op(ALU_SB, 32'h305, 32'hFFFF_FF5A, 5'd0);
        run_op(ALU_SH, 32'h306, 32'h0000_BEEF, 5'd0);
        run_op(ALU_LW, 32'h304, 32'h0, 5'd15);
        chk("lit_lw_merged", last_resp, 32'hBEEF_5A00);
        run_op(ALU_LH, 32'h306, 32'h0, 5'd16);
        chk("lit_lh_sext", last_resp, 32'hFFFF_BEEF);
        run_op(ALU_LHU, 32'h306, 32'h0, 5'd17);
        chk("lit_lhu_zext", last_resp, 32'h0000_BEEF);
        run_op(6'd63, 32'h100, 32'hFFFF_FFFF, 5'd7);
        chk("lit_unknown_data", last_resp, 32'h0);
        chk("lit_unknown_rd", {27'd0, last_rd}, 32'd0);
        run_reset_mid_store(32'h2F9, 32'h5566_7788);
        run_op(ALU_LW, 32'h104, 32'h0, 5'd18);
        chk("lit_after_reset", last_resp, 32'h8877_6655);

        repeat (2) @(posedge clk);
        for (int i = 0; i < 256; i++) chk($sformatf("mem_word_%0d", i), mem[i], exp_mem[i]);
        chk("exp_queue_drained", expq.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/memory_access_unit.md
MEMORY_ACCESS_UNIT -- requirements
Module: memory_access_unit

Interface
REQ-001 SHALL have the port: clk  input  1  the single system clock; all state updates on its rising edge.
REQ-002 SHALL have the port: rst  input  1  reset; synchronous, active-high.
REQ-003 SHALL have the ports: req_valid  input  1 / req_ready  output  1  request handshake from the execute stage.
REQ-004 SHALL have the ports: req_alucode  input  6  load/store opcode (ALU_LB/LH/LW/LBU/LHU/SB/SH/SW); req_addr  input  32  byte address; req_wdata  input  32  store data; req_rd  input  5  destination register.
REQ-005 SHALL have the ports: mem_is_store  output  1; mem_alucode  output  6; mem_w_addr  output  32; mem_w_data_byte  output  8; mem_w_data_half  output  16; mem_w_data_word  output  32  data-memory write side; the write commits at the same clock edge.
REQ-006 SHALL have the ports: mem_r_addr  output  32 / mem_r_data_word  input  32  data-memory read side; the read is combinational, same cycle.
REQ-007 SHALL have the ports: resp_valid  output  1  one-cycle completion pulse; resp_rd  output  5; resp_data  output  32  extended load result.

Function
REQ-008 SHALL accept a request on a rising edge with req_valid=1 and req_ready=1; req_ready SHALL be 1 only in IDLE; all req_* values are latched at acceptance.
REQ-009 SHALL use an FSM with states IDLE, RD_LO, RD_HI, WR, RESP.
REQ-010 Memory byte order SHALL be little-endian: byte k of a word is bits 8k+7:8k, word index addr>>2.
REQ-011 A request SHALL be misaligned for: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0. Byte accesses are never misaligned.
REQ-012 Aligned load: IDLE->RD_LO (mem_r_addr={addr[31:2],2'b00}, capture word)->RESP; resp_valid SHALL be asserted in the 2nd cycle after acceptance.
REQ-013 Misaligned load: RD_LO then RD_HI (word addr+4), then RESP; the result SHALL be bits 31:0 of ({hi,lo} >> 8*addr[1:0]); resp_valid SHALL be asserted in the 3rd cycle after acceptance.
REQ-014 Load extension: LB/LH SHALL sign-extend; LBU/LHU SHALL zero-extend; LW SHALL pass 32 bits.
REQ-015 Aligned store: one WR cycle driving mem_is_store=1, mem_alucode=req_alucode, mem_w_addr=addr, and byte/half/word data from req_wdata[7:0]/[15:0]/[31:0]; RESP follows.
REQ-016 Misaligned store: WR SHALL issue N byte stores (N=2 for SH, 4 for SW), one per cycle, mem_alucode=ALU_SB, address addr+i, data byte i of req_wdata, i=0..N-1 ascending; a 2-bit counter SHALL track i; RESP follows the last byte.
REQ-017 Addresses SHALL wrap modulo 2^32 (addr+4, addr+i).
REQ-018 In RESP: resp_valid=1 for exactly one cycle; for a load, resp_rd=latched rd and resp_data=the result; for a store, resp_rd=0 and resp_data=0; next state IDLE.
REQ-019 An unrecognised alucode SHALL be accepted, perform no memory write, and go directly to RESP with resp_rd=0 and resp_data=0.
REQ-020 mem_is_store SHALL be 1 only in WR.
REQ-021 Outside WR, mem_w_* and mem_alucode SHALL be 0.
REQ-022 mem_r_addr SHALL be 0 outside RD_LO/RD_HI.
REQ-023 A new request SHALL NOT be accepted in the RESP cycle; back-to-back throughput is one request per (latency+1) cycles.

Reset
REQ-024 When rst=1 at a rising edge, the state SHALL be IDLE; req_ready=1, resp_valid=0, resp_rd=0, resp_data=0, mem_is_store=0, all mem_* outputs=0, counter=0.
REQ-025 Reset mid-operation SHALL abort the operation: no further byte writes are issued, bytes already written remain, and no resp_valid is produced.
REQ-026 rst SHALL take priority over req_valid in the same cycle.

Structure
REQ-027 The ALU_* load/store opcode constants and the FSM state encodings SHALL live in the shared definitions header already used by data_memory.
REQ-028 Load alignment and extension SHALL be one combinational sub-module, load_aligner: inputs lo, hi, offset, alucode; output 32-bit result.

Verification
REQ-029 Aligned LW at 0x100, mem[0x40]=0xDEADBEEF -> resp_valid 2 cycles after accept, resp_data=0xDEADBEEF.
REQ-030 LB at 0x103 with word 0x80FF_0000 -> resp_data=0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-031 Misaligned LW at 0x102 (word 0x100=0x44332211, word 0x104=0x88776655) -> resp_data=0x66554433 after 3 cycles; req_ready=0 throughout.
REQ-032 Misaligned SW at 0x1FF, data 0xAABBCCDD -> four SB writes to 0x1FF/0x200/0x201/0x202 with DD/CC/BB/AA, then resp_valid with resp_rd=0.
REQ-033 rst asserted during the 2nd byte of a misaligned SW -> only byte 0 written, no resp_valid, IDLE with req_ready=1 next cycle.
REQ-034 LH at 0xFFFFFFFF -> high byte read from word 0x00000000 (wrap), result sign-extended.
